// File: rtl/kinetics_pkg.sv
// Shared types and constants for the reactor-kinetics step sequencer.
// Covers the precursor group count, the group index type and the sequencer states.
package kinetics_pkg;

    localparam int NUM_PRECURSOR_GROUPS = 6;

    typedef logic [2:0] grp_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        SETTLE,
        REQ,
        DONE
    } seq_state_t;

    localparam grp_idx_t LAST_GRP = grp_idx_t'(NUM_PRECURSOR_GROUPS - 1);

    function automatic logic is_last_group(input grp_idx_t idx);
        return idx == LAST_GRP;
    endfunction

endpackage

// File: rtl/step_tick_divider.sv
// Divides the system clock into physics timesteps.
// The tick marks the last cycle of each timestep.
module step_tick_divider #(
    parameter int CYCLES_PER_STEP = 6103
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic enable_in,
    output logic tick_out
);

    localparam int CNT_W = $clog2(CYCLES_PER_STEP);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_STEP - 1);

    logic [CNT_W-1:0] div_cnt;

    // The counter holds at zero while disabled, so every free-run phase starts a full step.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_cnt <= '0;
        end else if (!enable_in) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST_CNT) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick_out = (div_cnt == LAST_CNT);

endmodule

// File: rtl/kinetics_step_sequencer.sv
// Paces the reactor simulation: strobes the flux model each timestep, waits out its latency,
// then walks the delayed-neutron precursor groups through the shared update unit.
import kinetics_pkg::*;

module kinetics_step_sequencer #(
    parameter int CYCLES_PER_STEP  = 6103,
    parameter int KINETICS_LATENCY = 5,
    parameter int ACK_TIMEOUT      = 64
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic        step_now_in,
    input  logic        clear_flags_in,
    output logic        new_timestep_out,
    output logic        grp_req_out,
    output logic [2:0]  grp_idx_out,
    input  logic        grp_ack_in,
    output logic        busy_out,
    output logic [31:0] step_count_out,
    output logic        overrun_out,
    output logic        fault_out
);

    localparam int SETTLE_W = $clog2(KINETICS_LATENCY + 1);
    localparam int WAIT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(KINETICS_LATENCY - 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(ACK_TIMEOUT - 1);

    seq_state_t          state;
    seq_state_t          state_next;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SETTLE_W-1:0] settle_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_next;
    grp_idx_t            grp_idx;
    grp_idx_t            grp_next;

    logic tick;
    logic start;
    logic overrun_set;
    logic timeout;
    logic step_done;

    step_tick_divider #(
        .CYCLES_PER_STEP(CYCLES_PER_STEP)
    ) u_divider (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .enable_in(enable_in),
        .tick_out (tick)
    );

    // A latched fault freezes the sequencer and also masks overrun reporting.
    assign start = !fault_out && (state == IDLE) &&
                   (tick || (step_now_in && !enable_in));
    assign overrun_set = tick && (state != IDLE) && !fault_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            settle_cnt <= '0;
            wait_cnt   <= '0;
            grp_idx    <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            wait_cnt   <= wait_next;
            grp_idx    <= grp_next;
        end
    end

    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        wait_next   = wait_cnt;
        grp_next    = grp_idx;
        timeout     = 1'b0;
        step_done   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                settle_next = SETTLE_LOAD;
                state_next  = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    grp_next   = '0;
                    wait_next  = '0;
                    state_next = REQ;
                end else begin
                    settle_next = settle_cnt - 1'b1;
                end
            end
            REQ: begin
                // An ack on the final allowed wait cycle still counts as accepted.
                if (grp_ack_in) begin
                    wait_next = '0;
                    if (is_last_group(grp_idx)) begin
                        state_next = DONE;
                    end else begin
                        grp_next = grp_idx + 1'b1;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    wait_next  = '0;
                    state_next = IDLE;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            DONE: begin
                step_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            new_timestep_out <= 1'b0;
            busy_out         <= 1'b0;
            step_count_out   <= '0;
            overrun_out      <= 1'b0;
            fault_out        <= 1'b0;
        end else begin
            new_timestep_out <= (state_next == FIRE);
            busy_out         <= (state_next != IDLE);
            if (step_done) begin
                step_count_out <= step_count_out + 32'd1;
            end
            // Setting a flag wins over a simultaneous clear.
            if (overrun_set) begin
                overrun_out <= 1'b1;
            end else if (clear_flags_in) begin
                overrun_out <= 1'b0;
            end
            if (timeout) begin
                fault_out <= 1'b1;
            end else if (clear_flags_in) begin
                fault_out <= 1'b0;
            end
        end
    end

    assign grp_req_out = (state == REQ);
    assign grp_idx_out = (state == REQ) ? grp_idx : '0;

endmodule

// File: tb/tb_kinetics_step_sequencer.sv
// Self-checking bench for kinetics_step_sequencer: a timeline model of each step
// is compared against the DUT every cycle, with literal checks on key scenarios.
module tb_kinetics_step_sequencer;

    localparam int CPS = 20;
    localparam int LAT = 5;
    localparam int TO  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        step_now = 1'b0;
    logic        clear_flags = 1'b0;
    logic        grp_ack = 1'b0;
    logic        new_timestep;
    logic        grp_req;
    logic [2:0]  grp_idx;
    logic        busy;
    logic [31:0] step_count;
    logic        overrun;
    logic        fault;

    kinetics_step_sequencer #(
        .CYCLES_PER_STEP (CPS),
        .KINETICS_LATENCY(LAT),
        .ACK_TIMEOUT     (TO)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .enable_in       (enable),
        .step_now_in     (step_now),
        .clear_flags_in  (clear_flags),
        .new_timestep_out(new_timestep),
        .grp_req_out     (grp_req),
        .grp_idx_out     (grp_idx),
        .grp_ack_in      (grp_ack),
        .busy_out        (busy),
        .step_count_out  (step_count),
        .overrun_out     (overrun),
        .fault_out       (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a step is a timeline anchored at its start cycle
    int          cyc;
    int          dc;
    bit          m_on;
    int          m_t0;
    int          m_grp;
    int          m_base;
    int          m_finish;
    bit          m_fault;
    bit          m_over;
    logic [31:0] m_count;
    bit          e_req, e_strobe, e_busy, m_tick, m_idle, m_start, set_fault, set_over;
    int          e_idx;

    int   strobes_seen = 0;
    int   req_cycles_seen = 0;
    int   idx3_cycle = -1;
    int   fault_rise_cycle = -1;
    logic req_prev = 1'b0;
    logic [2:0] idx_prev = 3'd0;
    logic fault_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0; dc = 0; m_on = 0; m_t0 = 0; m_grp = 0; m_base = 0; m_finish = -1;
            m_fault = 0; m_over = 0; m_count = '0;
            checkOutput("rst_new_timestep", new_timestep, 0);
            checkOutput("rst_grp_req", grp_req, 0);
            checkOutput("rst_grp_idx", grp_idx, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_step_count", step_count, 0);
            checkOutput("rst_overrun", overrun, 0);
            checkOutput("rst_fault", fault, 0);
        end else begin
            e_strobe = m_on && (cyc == m_t0 + 1);
            e_busy   = m_on;
            e_req    = m_on && (cyc >= m_t0 + 2 + LAT) && (m_finish < 0);
            e_idx    = e_req ? m_grp : 0;
            checkOutput("new_timestep", new_timestep, e_strobe);
            checkOutput("grp_req", grp_req, e_req);
            checkOutput("grp_idx", grp_idx, e_idx);
            checkOutput("busy", busy, e_busy);
            checkOutput("step_count", step_count, m_count);
            checkOutput("overrun", overrun, m_over);
            checkOutput("fault", fault, m_fault);

            if (new_timestep) strobes_seen++;
            if (grp_req) req_cycles_seen++;
            if (grp_req && grp_idx == 3'd3 && !(req_prev && idx_prev == 3'd3)) idx3_cycle = cyc;
            if (fault && !fault_prev) fault_rise_cycle = cyc;
            req_prev = grp_req; idx_prev = grp_idx; fault_prev = fault;

            m_idle = !m_on;
            m_tick = (dc == CPS - 1);
            set_fault = 0;
            if (e_req) begin
                if (grp_ack) begin
                    if (m_grp == 5) m_finish = cyc + 1;
                    else begin m_grp++; m_base = cyc + 1; end
                end else if (cyc - m_base == TO - 1) begin
                    set_fault = 1;
                    m_on = 0;
                end
            end
            if (m_on && cyc == m_finish) begin
                m_count++;
                m_on = 0;
            end
            set_over = m_tick && !m_idle && !m_fault;
            m_start  = !m_fault && m_idle && (m_tick || (step_now && !enable));
            if (m_start) begin
                m_on = 1; m_t0 = cyc; m_grp = 0; m_base = cyc + 2 + LAT; m_finish = -1;
            end
            m_fault = set_fault ? 1'b1 : (clear_flags ? 1'b0 : m_fault);
            m_over  = set_over  ? 1'b1 : (clear_flags ? 1'b0 : m_over);
            dc = enable ? (m_tick ? 0 : dc + 1) : 0;
            cyc++;
        end
    end

    // Precursor-unit stand-in: acks after a programmable wait, or randomly
    int   ack_delay = 0;
    int   never_grp = -1;
    bit   rand_ack = 0;
    int   waited = 0;
    logic last_req = 1'b0;
    logic [2:0] last_idx = 3'd0;

    always @(posedge clk) begin
        #1;
        if (grp_req && last_req && grp_idx == last_idx) waited++;
        else waited = 0;
        last_req = grp_req;
        last_idx = grp_idx;
        if (rand_ack)
            grp_ack = (grp_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
        else
            grp_ack = grp_req && (int'(grp_idx) != never_grp) && (waited >= ack_delay);
    end

    task automatic applyStimulus(input bit en, input bit sn, input bit clr, input int cycles);
        enable = en;
        step_now = sn;
        clear_flags = clr;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic clearMonitors();
        strobes_seen = 0;
        req_cycles_seen = 0;
    endtask

    initial begin
        bit found;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_count", step_count, 0);
        rst_n = 1'b1;

        // Free run with immediate acks
        clearMonitors();
        applyStimulus(1, 0, 0, 100);
        applyStimulus(0, 0, 0, 30);
        checkOutput("free_count", step_count, 5);
        checkOutput("free_strobes", strobes_seen, 5);
        checkOutput("free_req_cycles", req_cycles_seen, 30);
        checkOutput("free_overrun", overrun, 0);
        checkOutput("free_fault", fault, 0);

        // Slow ack, single-stepped
        ack_delay = 3;
        clearMonitors();
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 45);
        checkOutput("slow_count", step_count, 6);
        checkOutput("slow_req_cycles", req_cycles_seen, 24);
        checkOutput("slow_fault", fault, 0);

        // Single step; second request while busy is ignored
        ack_delay = 0;
        clearMonitors();
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 4);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 20);
        checkOutput("single_count", step_count, 7);
        checkOutput("single_strobes", strobes_seen, 1);
        checkOutput("single_req_cycles", req_cycles_seen, 6);

        // Overrun: acks on the last allowed wait cycle stretch the step past the next tick
        ack_delay = TO - 1;
        clearMonitors();
        applyStimulus(1, 0, 0, 40);
        applyStimulus(0, 0, 0, 60);
        checkOutput("overrun_flag", overrun, 1);
        checkOutput("overrun_count", step_count, 8);
        checkOutput("overrun_strobes", strobes_seen, 1);
        checkOutput("overrun_no_fault", fault, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 2);
        checkOutput("overrun_cleared", overrun, 0);

        // Timeout on group 3
        ack_delay = 0;
        never_grp = 3;
        clearMonitors();
        applyStimulus(1, 0, 0, 60);
        checkOutput("timeout_fault", fault, 1);
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_count", step_count, 8);
        checkOutput("timeout_strobes", strobes_seen, 1);
        checkOutput("timeout_overrun", overrun, 0);
        checkOutput("timeout_latency", fault_rise_cycle - idx3_cycle, 8);
        never_grp = -1;
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 2);
        checkOutput("timeout_cleared", fault, 0);

        // Randomised traffic, checked by the model every cycle
        rand_ack = 1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0, $urandom_range(1, 40));
        end
        rand_ack = 0;
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 40);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 3);

        // Reset while group 4 is requested
        ack_delay = 3;
        applyStimulus(0, 1, 0, 1);
        step_now = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (grp_req && grp_idx == 3'd4) found = 1;
            else begin @(posedge clk); #1; end
        end
        checkOutput("reach_idx4", found, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_req", grp_req, 0);
        checkOutput("midreset_idx", grp_idx, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_count", step_count, 0);
        checkOutput("midreset_strobe", new_timestep, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(0, 0, 0, 3);
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_count", step_count, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 40);
        checkOutput("post_reset_step", step_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
